// File: rtl/pkg_tpu.sv
// Shared definitions for the MPU->TPU thread dispatch protocol.
// The MPU dispatch encoder builds headers from the same field offsets.
package pkg_tpu;

    localparam int WIDTH_INSTR     = 32;
    localparam int WIDTH_ENTRY_STH = 4;
    localparam int DEPTH_IMEM      = 1024;
    localparam int WIDTH_ADDR      = $clog2(DEPTH_IMEM);
    localparam int WIDTH_LEN       = WIDTH_ADDR + 1;

    // Header layout: issue number in the low bits, thread length directly above it
    localparam int HDR_ISSUE_LSB = 0;
    localparam int HDR_LEN_LSB   = WIDTH_ENTRY_STH;

    localparam logic [WIDTH_LEN-1:0] LEN_MAX = WIDTH_LEN'(DEPTH_IMEM);

    typedef struct packed {
        logic                   v;
        logic [WIDTH_INSTR-1:0] instr;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_RUN    = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DRAIN  = 3'd4
    } rcv_state_t;

endpackage

// File: rtl/imem_tpu.sv
// Local instruction memory: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module imem_tpu #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Array itself is never reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_recv_tpu.sv
// TPU receiver for MPU-dispatched threads: loads a thread into local imem,
// starts the sequencer, then requests commit of the thread's issue number.
module instr_recv_tpu
    import pkg_tpu::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       I_Req,
    input  instr_t                     I_Instr,
    output logic                       O_Busy,
    output logic                       O_Start,
    output logic [WIDTH_LEN-1:0]       O_Length,
    input  logic                       I_End_Exe,
    input  logic                       I_Rd_En,
    input  logic [WIDTH_ADDR-1:0]      I_Rd_Addr,
    output logic [WIDTH_INSTR-1:0]     O_Rd_Instr,
    output logic                       O_Req_Commit,
    output logic [WIDTH_ENTRY_STH-1:0] O_CommitNo,
    input  logic                       I_Ack_Commit,
    output logic [1:0]                 O_Err
);

    rcv_state_t                 state_q, state_d;
    logic [WIDTH_ENTRY_STH-1:0] issue_q, issue_d;
    logic [WIDTH_LEN-1:0]       len_q, len_d;
    logic [WIDTH_LEN-1:0]       cnt_q, cnt_d;
    logic                       start_q, start_d;
    logic [1:0]                 err_q, err_d;

    logic                       accept;
    logic                       last_word;
    logic                       wr_en;
    logic [WIDTH_ENTRY_STH-1:0] hdr_issue;
    logic [WIDTH_LEN-1:0]       hdr_len;

    assign accept    = I_Req & I_Instr.v;
    assign last_word = (cnt_q == len_q - 1'b1);
    assign hdr_issue = I_Instr.instr[HDR_ISSUE_LSB +: WIDTH_ENTRY_STH];
    assign hdr_len   = I_Instr.instr[HDR_LEN_LSB +: WIDTH_LEN];

    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        start_d = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    issue_d = hdr_issue;
                    len_d   = hdr_len;
                    cnt_d   = '0;
                    if (hdr_len == '0) begin
                        state_d = ST_COMMIT;
                    end else if (hdr_len > LEN_MAX) begin
                        state_d  = ST_DRAIN;
                        err_d[0] = 1'b1;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (accept) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = ST_RUN;
                        start_d = 1'b1;
                    end
                end
            end
            // Oversize thread is swallowed whole so the MPU still gets its commit
            ST_DRAIN: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    err_d[1] = 1'b1;
                end
                if (I_End_Exe) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (accept) begin
                    err_d[1] = 1'b1;
                end
                if (I_Ack_Commit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            issue_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    imem_tpu #(
        .WIDTH (WIDTH_INSTR),
        .DEPTH (DEPTH_IMEM)
    ) u_imem (
        .clk     (clock),
        .rst     (reset),
        .wr_en   (wr_en),
        .wr_addr (cnt_q[WIDTH_ADDR-1:0]),
        .wr_data (I_Instr.instr),
        .rd_en   (I_Rd_En),
        .rd_addr (I_Rd_Addr),
        .rd_data (O_Rd_Instr)
    );

    assign O_Busy       = (state_q != ST_IDLE);
    assign O_Start      = start_q;
    assign O_Length     = len_q;
    assign O_Req_Commit = (state_q == ST_COMMIT);
    assign O_CommitNo   = issue_q;
    assign O_Err        = err_q;

endmodule

// File: tb/tb_instr_recv_tpu.sv
// Randomized thread-level bench for instr_recv_tpu against a simple
// transaction model (memory image, sticky error bits, expected commit number).
module tb_instr_recv_tpu;
    import pkg_tpu::*;

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       I_Req;
    instr_t                     I_Instr;
    logic                       O_Busy;
    logic                       O_Start;
    logic [WIDTH_LEN-1:0]       O_Length;
    logic                       I_End_Exe;
    logic                       I_Rd_En;
    logic [WIDTH_ADDR-1:0]      I_Rd_Addr;
    logic [WIDTH_INSTR-1:0]     O_Rd_Instr;
    logic                       O_Req_Commit;
    logic [WIDTH_ENTRY_STH-1:0] O_CommitNo;
    logic                       I_Ack_Commit;
    logic [1:0]                 O_Err;

    instr_recv_tpu dut (
        .clock        (clock),
        .reset        (reset),
        .I_Req        (I_Req),
        .I_Instr      (I_Instr),
        .O_Busy       (O_Busy),
        .O_Start      (O_Start),
        .O_Length     (O_Length),
        .I_End_Exe    (I_End_Exe),
        .I_Rd_En      (I_Rd_En),
        .I_Rd_Addr    (I_Rd_Addr),
        .O_Rd_Instr   (O_Rd_Instr),
        .O_Req_Commit (O_Req_Commit),
        .O_CommitNo   (O_CommitNo),
        .I_Ack_Commit (I_Ack_Commit),
        .O_Err        (O_Err)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] ref_mem [DEPTH_IMEM];
    bit          ref_ok  [DEPTH_IMEM];
    logic [1:0]  ref_err = 2'b00;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        I_Req        = 1'b0;
        I_Instr      = '0;
        I_End_Exe    = 1'b0;
        I_Rd_En      = 1'b0;
        I_Rd_Addr    = '0;
        I_Ack_Commit = 1'b0;
    endtask

    function automatic logic [31:0] make_hdr(input int issue, input int len);
        logic [31:0] h;
        h = $urandom();
        h[HDR_ISSUE_LSB +: WIDTH_ENTRY_STH] = WIDTH_ENTRY_STH'(issue);
        h[HDR_LEN_LSB +: WIDTH_LEN]         = WIDTH_LEN'(len);
        return h;
    endfunction

    // Read back n random addresses from [0, span) that the model knows
    task automatic readback(input int n, input int span, inout int starts);
        int a;
        for (int k = 0; k < n; k++) begin
            a = $urandom_range(span - 1);
            I_Rd_En   = 1'b1;
            I_Rd_Addr = WIDTH_ADDR'(a);
            step();
            idle_inputs();
            starts += int'(O_Start);
            if (ref_ok[a]) check_val("imem_read", O_Rd_Instr, ref_mem[a]);
        end
    endtask

    // bub < 0: random 0..2 non-accepted cycles before each word
    task automatic run_thread(input int issue, input int len, input int bub,
                              input int ack_dly, input bit run_word);
        bit          oversize;
        int          starts;
        int          nb;
        bit          known;
        logic [31:0] w;
        logic [31:0] old;
        oversize = (len > DEPTH_IMEM);
        starts   = 0;
        if (oversize) ref_err[0] = 1'b1;

        I_Req   = 1'b1;
        I_Instr = {1'b1, make_hdr(issue, len)};
        step();
        idle_inputs();
        starts += int'(O_Start);
        check_val("hdr_err", O_Err, ref_err);
        if (len == 0) begin
            check_val("zero_len_req", O_Req_Commit, 1);
            check_val("zero_len_no", O_CommitNo, issue);
        end else begin
            check_val("hdr_busy", O_Busy, 1);
        end

        for (int i = 0; i < len; i++) begin
            nb = (bub < 0) ? $urandom_range(2) : bub;
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(1) == 1) begin
                    I_Req   = 1'b0;
                    I_Instr = {1'($urandom_range(1)), 32'($urandom())};
                end else begin
                    I_Req   = 1'($urandom_range(1));
                    I_Instr = {1'b0, 32'($urandom())};
                end
                I_End_Exe    = 1'($urandom_range(1));
                I_Ack_Commit = 1'($urandom_range(1));
                step();
                idle_inputs();
                starts += int'(O_Start);
            end
            w       = $urandom();
            I_Req   = 1'b1;
            I_Instr = {1'b1, w};
            known   = 1'b0;
            old     = '0;
            if (!oversize) begin
                I_Rd_En   = 1'b1;
                I_Rd_Addr = WIDTH_ADDR'(i);
                known     = ref_ok[i];
                old       = ref_mem[i];
            end
            step();
            idle_inputs();
            starts += int'(O_Start);
            if (known) check_val("rd_old_data", O_Rd_Instr, old);
            if (!oversize) begin
                ref_mem[i] = w;
                ref_ok[i]  = 1'b1;
            end
            if (i == len - 1) begin
                if (oversize) begin
                    check_val("drain_commit", O_Req_Commit, 1);
                    check_val("drain_no_start", O_Start, 0);
                end else begin
                    check_val("start_pulse", O_Start, 1);
                    check_val("length", O_Length, len);
                end
            end
        end

        if (len > 0 && !oversize) begin
            if (run_word) begin
                I_Req        = 1'b1;
                I_Instr      = {1'b1, 32'($urandom())};
                I_Ack_Commit = 1'b1;
                step();
                idle_inputs();
                starts += int'(O_Start);
                ref_err[1] = 1'b1;
                check_val("run_word_err", O_Err, ref_err);
            end
            readback(3, len, starts);
            check_val("run_busy", O_Busy, 1);
            check_val("run_no_req", O_Req_Commit, 0);
            I_End_Exe = 1'b1;
            step();
            idle_inputs();
            starts += int'(O_Start);
            check_val("commit_req", O_Req_Commit, 1);
            check_val("commit_no", O_CommitNo, issue);
        end

        for (int d = 0; d < ack_dly; d++) begin
            if ($urandom_range(1) == 1) begin
                I_Req      = 1'b1;
                I_Instr    = {1'b1, 32'($urandom())};
                ref_err[1] = 1'b1;
            end
            I_End_Exe = 1'($urandom_range(1));
            step();
            idle_inputs();
            check_val("commit_hold_req", O_Req_Commit, 1);
            check_val("commit_hold_no", O_CommitNo, issue);
        end

        I_Ack_Commit = 1'b1;
        step();
        idle_inputs();
        check_val("after_ack_busy", O_Busy, 0);
        check_val("after_ack_req", O_Req_Commit, 0);
        check_val("thread_err", O_Err, ref_err);
        check_val("start_count", starts, (len > 0 && !oversize) ? 1 : 0);
        $display("thread issue=%0d len=%0d ack_dly=%0d run_word=%0d err=%b", issue, len, ack_dly, run_word, O_Err);
    endtask

    initial begin
        int dummy;
        int len;
        dummy = 0;
        reset = 1'b1;
        idle_inputs();
        #1;
        check_val("reset_busy", O_Busy, 0);
        check_val("reset_req", O_Req_Commit, 0);
        check_val("reset_err", O_Err, 0);
        step();
        step();
        reset = 1'b0;
        step();

        run_thread(5, 3, 0, 0, 1'b0);
        run_thread(5, 3, 1, 0, 1'b0);
        run_thread(9, 0, 0, 0, 1'b0);
        run_thread(int'($urandom_range(15)), DEPTH_IMEM + 1, 0, 0, 1'b0);
        readback(3, 3, dummy);
        run_thread(11, 4, 0, 4, 1'b1);

        // Abort a four-word thread after two words with an asynchronous reset
        I_Req   = 1'b1;
        I_Instr = {1'b1, make_hdr(7, 4)};
        step();
        for (int i = 0; i < 2; i++) begin
            I_Instr = {1'b1, 32'($urandom())};
            ref_mem[i] = I_Instr.instr;
            ref_ok[i]  = 1'b1;
            step();
        end
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        ref_err = 2'b00;
        check_val("rst_busy", O_Busy, 0);
        check_val("rst_start", O_Start, 0);
        check_val("rst_length", O_Length, 0);
        check_val("rst_req", O_Req_Commit, 0);
        check_val("rst_commit_no", O_CommitNo, 0);
        check_val("rst_err", O_Err, 0);
        check_val("rst_rd_instr", O_Rd_Instr, 0);
        #1 reset = 1'b0;
        step();
        check_val("post_rst_req", O_Req_Commit, 0);
        run_thread(3, 4, 0, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 12));
            run_thread(int'($urandom_range(15)), len, -1, int'($urandom_range(3)),
                       $urandom_range(3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
